bcd_countdown: RTL and testbench

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_countdown.sv | 134 +++++++++++++
 tb/tb_bcd_countdown.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer ticked by an asynchronous 1 Hz input, with load/start/pause control.
// Optional: define COUNTDOWN_AUTORELOAD_EN to restart from the reload value on reaching 00.
module bcd_countdown #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_1hz,
   input  logic       load,
   input  logic [3:0] preset_l,
   input  logic [3:0] preset_h,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] digit_l,
   output logic [3:0] digit_h,
   output logic [1:0] state,
   output logic       done,
   output logic       zero_pulse
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t st_q, st_n;
   logic [3:0] dl_q, dh_q, dl_n, dh_n;
   logic [3:0] rl_q, rh_q, rl_n, rh_n;
   logic       zp_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic       last_q;
   logic       tick;
   logic [3:0] dec_l, dec_h;
   logic       cnt_zero, dec_zero;

   function automatic logic [3:0] clamp(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign tick = sync_q[SYNC_STAGES-1] & ~last_q;

   // BCD borrow: ones digit wraps 0 -> 9 and takes one from the tens digit
   always_comb begin
      dec_l = dl_q - 4'd1;
      dec_h = dh_q;
      if (dl_q == 4'd0) begin
         dec_l = 4'd9;
         dec_h = dh_q - 4'd1;
      end
   end

   assign cnt_zero = (dl_q == 4'd0) && (dh_q == 4'd0);
   assign dec_zero = (dec_l == 4'd0) && (dec_h == 4'd0);

   always_comb begin
      st_n = st_q;
      dl_n = dl_q;
      dh_n = dh_q;
      rl_n = rl_q;
      rh_n = rh_q;
      zp_n = 1'b0;
      if (load) begin
         dl_n = clamp(preset_l);
         dh_n = clamp(preset_h);
         rl_n = clamp(preset_l);
         rh_n = clamp(preset_h);
         st_n = IDLE;
      end else begin
         case (st_q)
            IDLE: if (start && !cnt_zero) st_n = RUN;
            RUN: begin
               // pause wins over a same-cycle tick; that tick is dropped
               if (pause) st_n = PAUSED;
               else if (tick && !cnt_zero) begin
                  dl_n = dec_l;
                  dh_n = dec_h;
                  if (dec_zero) begin
                     zp_n = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     if ((rl_q != 4'd0) || (rh_q != 4'd0)) begin
                        dl_n = rl_q;
                        dh_n = rh_q;
                     end else begin
                        st_n = DONE;
                     end
`else
                     st_n = DONE;
`endif
                  end
               end
            end
            PAUSED: if (!pause) st_n = RUN;
            DONE: begin
               if (start) begin
                  dl_n = rl_q;
                  dh_n = rh_q;
                  if ((rl_q != 4'd0) || (rh_q != 4'd0)) st_n = RUN;
               end
            end
            default: st_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= IDLE;
         dl_q       <= 4'd0;
         dh_q       <= 4'd0;
         rl_q       <= 4'd0;
         rh_q       <= 4'd0;
         zero_pulse <= 1'b0;
         sync_q     <= '0;
         last_q     <= 1'b0;
      end else begin
         st_q       <= st_n;
         dl_q       <= dl_n;
         dh_q       <= dh_n;
         rl_q       <= rl_n;
         rh_q       <= rh_n;
         zero_pulse <= zp_n;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_1hz};
         last_q     <= sync_q[SYNC_STAGES-1];
      end
   end

   assign digit_l = dl_q;
   assign digit_h = dh_q;
   assign state   = st_q;
   assign done    = (st_q == DONE);

endmodule

// File: tb/tb_bcd_countdown.sv
// Scoreboard bench for bcd_countdown: stimulus queues expected output changes, a monitor pops and compares.
module tb_bcd_countdown;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_1hz = 1'b0;
   logic       load = 1'b0;
   logic [3:0] preset_l = 4'd0;
   logic [3:0] preset_h = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] digit_l, digit_h;
   logic [1:0] state;
   logic       done, zero_pulse;

   localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10, S_DONE = 2'b11;

   bcd_countdown #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .load(load),
      .preset_l(preset_l), .preset_h(preset_h), .start(start), .pause(pause),
      .digit_l(digit_l), .digit_h(digit_h), .state(state), .done(done),
      .zero_pulse(zero_pulse)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic        mon_en = 1'b0;
   logic [11:0] exp_q[$];
   logic [11:0] m_cur = 12'd0;
   logic [11:0] mon_prev = 12'd0;
   logic [11:0] mon_cur, mon_exp;

   // record layout: {tens, ones, state, done, zero_pulse}
   function automatic logic [11:0] mk(input logic [3:0] h, input logic [3:0] l,
                                      input logic [1:0] st, input logic zp);
      return {h, l, st, (st == S_DONE), zp};
   endfunction

   function automatic logic [11:0] snap();
      return {digit_h, digit_l, state, done, zero_pulse};
   endfunction

   function automatic void chk(input string name, input logic [11:0] act, input logic [11:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endfunction

   // only visible output changes are queued, matching what the monitor detects
   function automatic void push_exp(input logic [11:0] v);
      if (v != m_cur) begin
         exp_q.push_back(v);
         m_cur = v;
      end
   endfunction

   always @(negedge clk) begin
      mon_cur = snap();
      if (mon_en && (mon_cur !== mon_prev)) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_change: got %h expected no change from %h", mon_cur, mon_prev);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("output_seq", mon_cur, mon_exp);
         end
      end
      mon_prev = mon_cur;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] h, input logic [3:0] l);
      preset_h = h;
      preset_l = l;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic tick();
      clk_1hz = 1'b1;
      cyc(4);
      clk_1hz = 1'b0;
      cyc(3);
   endtask

   initial begin
      int w;
      cyc(3);
      chk("reset_state", snap(), mk(4'd0, 4'd0, S_IDLE, 1'b0));
      rst = 1'b0;
      mon_en = 1'b1;

      // count 12 down to 00
      push_exp(mk(4'd1, 4'd2, S_IDLE, 1'b0));
      do_load(4'd1, 4'd2);
      push_exp(mk(4'd1, 4'd2, S_RUN, 1'b0));
      do_start();
      for (int n = 12; n >= 1; n--) begin
         if (n > 1) push_exp(mk(4'((n - 1) / 10), 4'((n - 1) % 10), S_RUN, 1'b0));
         else begin
            push_exp(mk(4'd0, 4'd0, S_DONE, 1'b1));
            push_exp(mk(4'd0, 4'd0, S_DONE, 1'b0));
         end
         tick();
      end
      chk("done_after_12", snap(), mk(4'd0, 4'd0, S_DONE, 1'b0));

      // clamp and start-at-zero
      push_exp(mk(4'd9, 4'd9, S_IDLE, 1'b0));
      do_load(4'hC, 4'hF);
      chk("clamp_99", snap(), mk(4'd9, 4'd9, S_IDLE, 1'b0));
      push_exp(mk(4'd0, 4'd0, S_IDLE, 1'b0));
      do_load(4'd0, 4'd0);
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      chk("start_at_zero", snap(), mk(4'd0, 4'd0, S_IDLE, 1'b0));

      // pause holds the count across ticks
      push_exp(mk(4'd0, 4'd6, S_IDLE, 1'b0));
      do_load(4'd0, 4'd6);
      push_exp(mk(4'd0, 4'd6, S_RUN, 1'b0));
      do_start();
      push_exp(mk(4'd0, 4'd5, S_RUN, 1'b0));
      tick();
      push_exp(mk(4'd0, 4'd5, S_PAUSED, 1'b0));
      pause = 1'b1;
      cyc(1);
      tick(); tick(); tick();
      chk("paused_hold", snap(), mk(4'd0, 4'd5, S_PAUSED, 1'b0));
      push_exp(mk(4'd0, 4'd5, S_RUN, 1'b0));
      pause = 1'b0;
      cyc(1);
      push_exp(mk(4'd0, 4'd4, S_RUN, 1'b0));
      tick();
      chk("resume_04", snap(), mk(4'd0, 4'd4, S_RUN, 1'b0));

      // reset coincident with a tick at 07
      push_exp(mk(4'd0, 4'd8, S_IDLE, 1'b0));
      do_load(4'd0, 4'd8);
      push_exp(mk(4'd0, 4'd8, S_RUN, 1'b0));
      do_start();
      push_exp(mk(4'd0, 4'd7, S_RUN, 1'b0));
      tick();
      clk_1hz = 1'b1;
      cyc(2);
      push_exp(mk(4'd0, 4'd0, S_IDLE, 1'b0));
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(3);
      clk_1hz = 1'b0;
      cyc(3);
      chk("rst_abort", snap(), mk(4'd0, 4'd0, S_IDLE, 1'b0));

      // tick latency: change lands on the 3rd edge after clk_1hz rises
      push_exp(mk(4'd0, 4'd3, S_IDLE, 1'b0));
      do_load(4'd0, 4'd3);
      push_exp(mk(4'd0, 4'd3, S_RUN, 1'b0));
      do_start();
      clk_1hz = 1'b1;
      cyc(1);
      chk("lat_edge1", snap(), mk(4'd0, 4'd3, S_RUN, 1'b0));
      cyc(1);
      chk("lat_edge2", snap(), mk(4'd0, 4'd3, S_RUN, 1'b0));
      push_exp(mk(4'd0, 4'd2, S_RUN, 1'b0));
      cyc(1);
      chk("lat_edge3", snap(), mk(4'd0, 4'd2, S_RUN, 1'b0));
      clk_1hz = 1'b0;
      cyc(3);

      // load coincident with a tick: preset wins, no decrement
      clk_1hz = 1'b1;
      cyc(2);
      push_exp(mk(4'd0, 4'd5, S_IDLE, 1'b0));
      do_load(4'd0, 4'd5);
      chk("load_vs_tick", snap(), mk(4'd0, 4'd5, S_IDLE, 1'b0));
      cyc(3);
      clk_1hz = 1'b0;
      cyc(3);
      chk("load_vs_tick_hold", snap(), mk(4'd0, 4'd5, S_IDLE, 1'b0));

      // reaching 00 from 02: reload or stop depending on build
      push_exp(mk(4'd0, 4'd2, S_IDLE, 1'b0));
      do_load(4'd0, 4'd2);
      push_exp(mk(4'd0, 4'd2, S_RUN, 1'b0));
      do_start();
      push_exp(mk(4'd0, 4'd1, S_RUN, 1'b0));
      tick();
`ifdef COUNTDOWN_AUTORELOAD_EN
      push_exp(mk(4'd0, 4'd2, S_RUN, 1'b1));
      push_exp(mk(4'd0, 4'd2, S_RUN, 1'b0));
      tick();
      chk("autoreload", snap(), mk(4'd0, 4'd2, S_RUN, 1'b0));
`else
      push_exp(mk(4'd0, 4'd0, S_DONE, 1'b1));
      push_exp(mk(4'd0, 4'd0, S_DONE, 1'b0));
      tick();
      chk("stop_at_00", snap(), mk(4'd0, 4'd0, S_DONE, 1'b0));
      push_exp(mk(4'd0, 4'd2, S_RUN, 1'b0));
      do_start();
      chk("restart_from_done", snap(), mk(4'd0, 4'd2, S_RUN, 1'b0));
`endif

      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         cyc(1);
         w++;
      end
      chk("queue_drained", 12'(exp_q.size()), 12'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
